// File: rtl/recovunit_stream.sv
// Check-node message recovery: expands one compressed min-sum row record into Wc/P beats of P signed messages.
// Optional RECOV_OFFSET_EN applies the offset-min-sum correction (BETA) to min1/min2 when the record is latched.
module recovunit_stream #(
  parameter int Wc     = 32,
  parameter int Wcbits = 6,
  parameter int W      = 10,
  parameter int P      = 8,
  parameter int BEATW  = 3,
  parameter int BETA   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W-2:0]       in_min1_i,
  input  logic [W-2:0]       in_min2_i,
  input  logic [Wcbits-1:0]  in_pos_i,
  input  logic [Wc-1:0]      in_sign_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [P*W-1:0]     out_data_o,
  output logic [BEATW-1:0]   out_beat_o,
  output logic               out_last_o,
  output logic               pos_err_o
);

  localparam int NBEAT = Wc / P;
`ifdef RECOV_OFFSET_EN
  localparam int OFS = BETA;
`else
  localparam int OFS = 0;
`endif

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t              state_q, state_d;
  logic [W-2:0]        min1_q, min1_d, min2_q, min2_d;
  logic [Wcbits-1:0]   pos_q, pos_d;
  logic [Wc-1:0]       sign_q, sign_d;
  logic [BEATW-1:0]    beat_q, beat_d, nxt_beat;
  logic [P*W-1:0]      data_q, data_d;
  logic                last_q, last_d;
  logic                perr_q, perr_d;
  logic                accept;
  logic [W-2:0]        min1_ofs, min2_ofs;

  // With OFS=0 this reduces to the identity, so one path serves both builds.
  function automatic logic [W-2:0] offset_mag(input logic [W-2:0] m);
    if (int'(m) > OFS) return m - (W-1)'(OFS);
    else               return '0;
  endfunction

  function automatic logic [P*W-1:0] beat_data(input logic [W-2:0]      m1,
                                               input logic [W-2:0]      m2,
                                               input logic [Wcbits-1:0] pos,
                                               input logic [Wc-1:0]     sgn,
                                               input logic [BEATW-1:0]  beat);
    logic [P*W-1:0]        d;
    logic [W-2:0]          mag;
    logic signed [W-1:0]   lane;
    int                    c;
    d = '0;
    for (int j = 0; j < P; j++) begin
      c    = int'(beat) * P + j;
      mag  = (c == int'(pos)) ? m2 : m1;
      lane = $signed({1'b0, mag});
      if (sgn[c]) lane = -lane;
      d[j*W +: W] = lane;
    end
    return d;
  endfunction

  assign min1_ofs = offset_mag(in_min1_i);
  assign min2_ofs = offset_mag(in_min2_i);
  assign nxt_beat = beat_q + BEATW'(1);

  always_comb begin
    state_d    = state_q;
    min1_d     = min1_q;
    min2_d     = min2_q;
    pos_d      = pos_q;
    sign_d     = sign_q;
    beat_d     = beat_q;
    data_d     = data_q;
    last_d     = last_q;
    perr_d     = perr_q;
    // A new record may enter while the final beat of the previous one drains.
    in_ready_o = (state_q == S_IDLE) || (last_q && out_ready_i);
    accept     = in_valid_i && in_ready_o;
    if (accept) begin
      min1_d  = min1_ofs;
      min2_d  = min2_ofs;
      pos_d   = in_pos_i;
      sign_d  = in_sign_i;
      beat_d  = '0;
      data_d  = beat_data(min1_ofs, min2_ofs, in_pos_i, in_sign_i, '0);
      last_d  = (NBEAT == 1);
      state_d = S_STREAM;
      if (int'(in_pos_i) >= Wc) perr_d = 1'b1;
    end else if (state_q == S_STREAM && out_ready_i) begin
      if (last_q) begin
        state_d = S_IDLE;
        last_d  = 1'b0;
      end else begin
        beat_d = nxt_beat;
        data_d = beat_data(min1_q, min2_q, pos_q, sign_q, nxt_beat);
        last_d = (int'(nxt_beat) == NBEAT - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

  // Record fields only matter once STREAM is entered, so they carry no reset.
  always_ff @(posedge clk_i) begin
    min1_q <= min1_d;
    min2_q <= min2_d;
    pos_q  <= pos_d;
    sign_q <= sign_d;
  end

  assign out_valid_o = (state_q == S_STREAM);
  assign out_data_o  = data_q;
  assign out_beat_o  = beat_q;
  assign out_last_o  = last_q;
  assign pos_err_o   = perr_q;

endmodule

// File: tb/tb_recovunit_stream.sv
// Directed bench for recovunit_stream: a queue-based model of expected beats checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_recovunit_stream;
  localparam int WC = 32, W = 10, P = 8, NB = 4, BETA = 1;

  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, pos_err;
  logic [8:0]  in_min1 = 0, in_min2 = 0;
  logic [5:0]  in_pos = 0;
  logic [31:0] in_sign = 0;
  logic [79:0] out_data;
  logic [2:0]  out_beat;

  int n_vec = 0, n_err = 0;
  bit armed = 0;
  bit m_perr = 0;
  int run = 0, max_run = 0;

  typedef struct { logic [79:0] data; int beat; bit last; } beat_t;
  beat_t exp_q[$];

  recovunit_stream dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_min1_i(in_min1), .in_min2_i(in_min2), .in_pos_i(in_pos), .in_sign_i(in_sign),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_beat_o(out_beat), .out_last_o(out_last), .pos_err_o(pos_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_lane(input int m1, input int m2, input int pos,
                                          input logic [31:0] s, input int c);
    int v;
    v = (c == pos) ? m2 : m1;
`ifdef RECOV_OFFSET_EN
    v = (v > BETA) ? v - BETA : 0;
`endif
    if (s[c]) v = -v;
    return 10'(v);
  endfunction

  function automatic logic [9:0] lane(input logic [79:0] d, input int j);
    return d[j*W +: W];
  endfunction

  // Model: every accepted record becomes NB expected beats; outputs are checked each cycle.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      exp_q.delete();
      m_perr = 0;
      run = 0;
    end else if (armed) begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
      chk("pos_err", pos_err, m_perr);
      if (out_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_beat", out_beat, exp_q[0].beat);
        chk("out_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < NB; k++) begin
          e.beat = k;
          e.last = (k == NB - 1);
          for (int j = 0; j < P; j++)
            e.data[j*W +: W] = exp_lane(in_min1, in_min2, in_pos, in_sign, k*P + j);
          exp_q.push_back(e);
        end
        if (in_pos >= 6'(WC)) m_perr = 1;
      end
    end
  end

  task automatic send(input logic [8:0] m1, input logic [8:0] m2, input logic [5:0] p,
                      input logic [31:0] s, input bit hold);
    in_valid = 1; in_min1 = m1; in_min2 = m2; in_pos = p; in_sign = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        if (!hold) in_valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [79:0] held;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beat", out_beat, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pos_err", pos_err, 0);
    armed = 1;
    @(posedge clk); #1;

    // Basic
    send(9'd5, 9'd9, 6'd3, 32'h0, 0);
    @(negedge clk);
    chk("basic_l0", lane(out_data, 0), 10'd5);
    chk("basic_l3", lane(out_data, 3), 10'd9);
    chk("basic_l7", lane(out_data, 7), 10'd5);
    chk("basic_last0", out_last, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("basic_beat3", out_beat, 3);
    chk("basic_last3", out_last, 1);
    chk("basic_l31", lane(out_data, 7), 10'd5);
    wait_idle();

    // Signs
    send(9'd2, 9'd7, 6'd31, 32'h8000_0001, 0);
    @(negedge clk);
    chk("sign_col0", lane(out_data, 0), 10'h3FE);
    chk("sign_col1", lane(out_data, 1), 10'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sign_col31", lane(out_data, 7), 10'h3F9);
    wait_idle();

    // Backpressure on beat 1
    send(9'd4, 9'd11, 6'd9, 32'h0000_0300, 0);
    @(posedge clk); #1;
    out_ready = 0;
    held = out_data;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data_hold", out_data, held);
      chk("bp_beat_hold", out_beat, 1);
    end
    chk("bp_col9", lane(held, 1), 10'h3F5);
    @(posedge clk); #1;
    out_ready = 1;
    wait_idle();

    // Back-to-back
    @(posedge clk); #1;
    max_run = 0;
    send(9'd1, 9'd3, 6'd0, 32'hF0F0_F0F0, 1);
    send(9'd6, 9'd8, 6'd20, 32'h0F0F_0F0F, 0);
    wait_idle();
    chk("b2b_run", max_run, 8);

    // Out-of-range position: all lanes min1, sticky error
    send(9'd5, 9'd9, 6'd40, 32'h0, 0);
    @(negedge clk);
    chk("pos40_l3", lane(out_data, 3), 10'd5);
    chk("pos40_err", pos_err, 1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("pos40_sticky", pos_err, 1);

    // Reset during beat 2
    send(9'd3, 9'd4, 6'd1, 32'h0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_pos_err", pos_err, 0);
    chk("rstmid_in_ready", in_ready, 1);

    // Zero magnitude with negative sign
    send(9'd0, 9'd1, 6'd5, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    chk("zero_l0", lane(out_data, 0), 10'h000);
`ifdef RECOV_OFFSET_EN
    chk("ofs_all0", out_data, 80'h0);
`else
    chk("zero_l5", lane(out_data, 5), 10'h3FF);
`endif
    wait_idle();

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
